// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and pipeline-stage control types for
// the request master.
//   htrans_e        HTRANS encoding (only IDLE and NONSEQ are driven)
//   HBURST_SINGLE   constant burst type
//   HPROT_DEFAULT   data access, privileged
//   HSIZE_*         transfer size encodings
//   a_ctl_t/d_ctl_t address-phase / data-phase control bits
package ahb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Address-phase stage; addr/wdata live in parallel registers so the
  // struct stays independent of the bus width parameters.
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] size;
    logic       lerr;   // never reaches the bus, completes as an error
  } a_ctl_t;

  typedef struct packed {
    logic valid;
    logic write;
    logic lerr;
  } d_ctl_t;
endpackage

// File: rtl/ahb_rsp_fifo.sv
// ahb_rsp_fifo: synchronous FIFO holding completed responses.
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_din (caller guarantees space)
//   i_pop      remove head (ignored when empty)
//   o_dout     head entry
//   o_count    number of stored entries (0..DEPTH)
//   o_empty    no entries
module ahb_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop, w_full;

  assign o_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // The upstream credit check keeps outstanding work within DEPTH.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));
endmodule

// File: rtl/ahb_req_master.sv
// ahb_req_master: valid/ready request stream to pipelined single AHB-Lite
// transfers, with one in-order response per request.
//   clk, rst                 bus clock, synchronous active-high reset
//   req_*                    request stream (write, addr, HSIZE, wdata)
//   rsp_*                    response stream (rdata, err)
//   HRESETn..HWDATA          master-side AHB-Lite signals
//   HREADY, HRESP, HRDATA    slave response
module ahb_req_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              HRESETn,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);
  localparam int MAX_SIZE = $clog2(DATA_W / 8);
  localparam int CNT_W    = $clog2(RSP_DEPTH) + 1;
  localparam int OUT_W    = CNT_W + 1;

  a_ctl_t            r_a;
  logic [ADDR_W-1:0] r_a_addr;
  logic [DATA_W-1:0] r_a_wdata;
  d_ctl_t            r_d;
  logic [DATA_W-1:0] r_d_wdata;
  logic              r_hresetn;

  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [OUT_W-1:0]  w_outstanding;
  logic [6:0]        w_amask;
  logic              w_lerr, w_accept, w_a_bus, w_push, w_pop, w_cmp_err, w_empty;
  logic [DATA_W:0]   w_fifo_din, w_fifo_dout;

  // Local checks: size wider than the data bus, or address misaligned.
  assign w_amask = 7'((8'd1 << req_size) - 8'd1);
  assign w_lerr  = (req_size > 3'(MAX_SIZE)) || (|(req_addr[6:0] & w_amask));

  // Credits count everything that will eventually need a FIFO slot.
  assign w_outstanding = OUT_W'(r_a.valid) + OUT_W'(r_d.valid) + OUT_W'(w_fifo_cnt);
  assign req_ready = !rst && (!r_a.valid || HREADY) && (w_outstanding < OUT_W'(RSP_DEPTH));
  assign w_accept  = req_valid && req_ready;

  // Address phase: only real (non-bubble) entries reach the bus.
  assign w_a_bus   = r_a.valid && !r_a.lerr;
  assign HTRANS    = w_a_bus ? NONSEQ : IDLE;
  assign HADDR     = w_a_bus ? r_a_addr : '0;
  assign HWRITE    = w_a_bus && r_a.write;
  assign HSIZE     = w_a_bus ? r_a.size : '0;
  assign HWDATA    = (r_d.valid && r_d.write) ? r_d_wdata : '0;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;
  assign HRESETn   = r_hresetn;
  assign HSEL      = r_hresetn;

  // Data-phase completion feeds the response FIFO.
  assign w_push     = r_d.valid && HREADY;
  assign w_cmp_err  = HRESP || r_d.lerr;
  assign w_fifo_din = {w_cmp_err, (!r_d.write && !w_cmp_err) ? HRDATA : '0};

  always_ff @(posedge clk) begin
    r_hresetn <= ~rst;
    if (rst) begin
      r_a       <= '0;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
      r_d       <= '0;
      r_d_wdata <= '0;
    end else begin
      if (HREADY) begin
        r_d       <= '{valid: r_a.valid, write: r_a.write, lerr: r_a.lerr};
        r_d_wdata <= r_a_wdata;
      end
      if (w_accept) begin
        r_a       <= '{valid: 1'b1, write: req_write, size: req_size, lerr: w_lerr};
        r_a_addr  <= req_addr;
        r_a_wdata <= req_wdata;
      end else if (HREADY) begin
        r_a.valid <= 1'b0;
      end else if (HRESP && r_a.valid) begin
        // First ERROR cycle: abandon the queued transfer; it turns into a
        // bubble that later completes with an error.
        r_a.lerr <= 1'b1;
      end
    end
  end

  assign rsp_valid = !w_empty;
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_err   = w_fifo_dout[DATA_W];
  assign rsp_rdata = w_fifo_dout[DATA_W-1:0];

  ahb_rsp_fifo #(.W(DATA_W + 1), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_cnt),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_ahb_req_master.sv
module tb_ahb_req_master;
  import ahb_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [2:0] req_size = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic HRESETn, HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [AW-1:0] HADDR;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  logic [DW-1:0] HWDATA, HRDATA;

  always #5 clk = ~clk;

  ahb_req_master #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [64];
  logic s_dv = 1'b0, s_dw = 1'b0;
  logic [AW-1:0] s_da = '0;
  int s_wait = 0, s_err = 0;
  logic [AW-1:0] wait_addr = '1, err_addr = '1;
  int wait_n = 0;
  int ap_cyc[$];
  logic [AW-1:0] ap_addr[$];

  initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;

  assign HREADY = !s_dv || (s_wait == 0 && s_err != 1);
  assign HRESP  = s_dv && s_err != 0;
  assign HRDATA = (s_dv && !s_dw && s_wait == 0 && s_err == 0) ? mem[s_da[7:2]] : '0;

  always @(posedge clk) begin
    if (rst) begin
      s_dv <= 1'b0; s_wait <= 0; s_err <= 0;
    end else if (s_dv && s_wait > 0) begin
      s_wait <= s_wait - 1;
    end else if (s_dv && s_err == 1) begin
      s_err <= 2;
    end else begin
      if (s_dv && s_dw && s_err == 0) mem[s_da[7:2]] <= HWDATA;
      if (HTRANS == NONSEQ) begin
        s_dv <= 1'b1; s_da <= HADDR; s_dw <= HWRITE;
        s_wait <= (HADDR == wait_addr) ? wait_n : 0;
        s_err  <= (HADDR == err_addr) ? 1 : 0;
        ap_cyc.push_back(cyc);
        ap_addr.push_back(HADDR);
      end else begin
        s_dv <= 1'b0; s_err <= 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [DW:0] exp_q[$];
  int rsp_cyc[$];
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got err=%b rdata=%h, none required", rsp_err, rsp_rdata);
      end else begin
        chk("rsp", {rsp_err, rsp_rdata}, exp_q.pop_front());
      end
    end
  end

  // Address/data must hold across plain wait states.
  logic p_stall = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [1:0] p_trans = '0;
  logic [2:0] p_size = '0;
  logic [DW-1:0] p_wd = '0;
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (!rst && p_stall) begin
      chk("hold_haddr", HADDR, p_addr);
      chk("hold_htrans", HTRANS, p_trans);
      chk("hold_hsize", HSIZE, p_size);
      chk("hold_hwdata", HWDATA, p_wd);
    end
    p_stall <= !rst && !HREADY && !HRESP && HTRANS == NONSEQ;
    p_addr <= HADDR; p_trans <= HTRANS; p_size <= HSIZE; p_wd <= HWDATA;
    if (!rst && !HREADY) wait_cnt <= wait_cnt + 1;
  end

  // ---------------- stimulus ----------------
  int last_acc = 0, stall_sum = 0;

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [2:0] sz,
                      input logic [DW-1:0] wd, input logic e, input logic [DW-1:0] rd);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_wdata = wd;
    exp_q.push_back({e, rd});
    @(negedge clk);
    while (!req_ready && n < 100) begin n++; @(negedge clk); end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: addr %h not accepted after %0d cycles", a, n);
    end
    stall_sum += n;
    last_acc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin n++; @(negedge clk); end
    chk(nm, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a0, ab;
    logic [31:0] t2_exp [8];
    t2_exp = '{32'h1000_0010, 32'h1000_0011, 32'h1000_0012, 32'h1000_0013,
               32'h1000_0014, 32'h1000_0015, 32'h1000_0016, 32'h1000_0017};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_hresetn", HRESETn, 0);
    chk("rst_hsel", HSEL, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_hresetn", HRESETn, 1);
    chk("post_rst_hsel", HSEL, 1);
    chk("hburst", HBURST, 0);
    chk("hprot", HPROT, 4'b0011);
    chk("hmastlock", HMASTLOCK, 0);
    chk("post_rst_req_ready", req_ready, 1);

    // 1: write then read back, zero waits
    rsp_cyc.delete(); ap_cyc.delete(); ap_addr.delete();
    send(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, 32'h0);
    a0 = last_acc;
    send(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);
    idle();
    drain("t1_drain");
    chk("t1_num_ap", ap_cyc.size(), 2);
    if (ap_cyc.size() == 2) chk("t1_nonseq_b2b", ap_cyc[1] - ap_cyc[0], 1);
    chk("t1_num_rsp", rsp_cyc.size(), 2);
    if (rsp_cyc.size() >= 1) chk("t1_latency", rsp_cyc[0] - a0, 3);

    // 2: 8 back-to-back reads
    rsp_cyc.delete(); stall_sum = 0;
    for (int i = 0; i < 8; i++) send(1'b0, 32'h40 + 4 * i, 3'd2, 32'h0, 1'b0, t2_exp[i]);
    idle();
    drain("t2_drain");
    chk("t2_no_stall", stall_sum, 0);
    chk("t2_num_rsp", rsp_cyc.size(), 8);
    if (rsp_cyc.size() == 8) chk("t2_rsp_rate", rsp_cyc[7] - rsp_cyc[0], 7);

    // 3: three wait states on the middle read
    wait_addr = 32'h64; wait_n = 3; ab = wait_cnt;
    send(1'b0, 32'h60, 3'd2, 32'h0, 1'b0, 32'h1000_0018);
    send(1'b0, 32'h64, 3'd2, 32'h0, 1'b0, 32'h1000_0019);
    send(1'b0, 32'h68, 3'd2, 32'h0, 1'b0, 32'h1000_001A);
    idle();
    drain("t3_drain");
    chk("t3_wait_cycles", wait_cnt - ab, 3);
    wait_addr = '1; wait_n = 0;

    // 4: ERROR on a write cancels the queued read
    err_addr = 32'h70; ab = ap_addr.size();
    send(1'b1, 32'h70, 3'd2, 32'hCAFE_F00D, 1'b1, 32'h0);
    send(1'b0, 32'h74, 3'd2, 32'h0, 1'b1, 32'h0);
    idle();
    drain("t4_drain");
    chk("t4_num_ap", ap_addr.size() - ab, 1);
    if (ap_addr.size() == ab + 1) chk("t4_ap_addr", ap_addr[ab], 32'h70);
    err_addr = '1;

    // 5: misaligned and oversize requests become bubbles
    ab = ap_addr.size();
    send(1'b0, 32'h80, 3'd2, 32'h0, 1'b0, 32'h1000_0020);
    send(1'b0, 32'h82, 3'd2, 32'h0, 1'b1, 32'h0);
    send(1'b0, 32'h88, 3'd3, 32'h0, 1'b1, 32'h0);
    send(1'b0, 32'h84, 3'd2, 32'h0, 1'b0, 32'h1000_0021);
    idle();
    drain("t5_drain");
    chk("t5_num_ap", ap_addr.size() - ab, 2);
    if (ap_addr.size() == ab + 2) begin
      chk("t5_ap0", ap_addr[ab], 32'h80);
      chk("t5_ap1", ap_addr[ab + 1], 32'h84);
    end

    // 6: back-pressure fills credits, then reset mid-stream
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 32'h90 + 4 * i, 3'd2, 32'h0, 1'b0, 32'h1000_0024 + i);
    idle();
    @(negedge clk);
    chk("t6_ready_low_full", req_ready, 0);
    repeat (4) @(negedge clk);
    chk("t6_rsp_valid_held", rsp_valid, 1);
    chk("t6_ready_still_low", req_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t6_ready_in_rst", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_htrans", HTRANS, 0);
    chk("t6_rst_haddr", HADDR, 0);
    chk("t6_rst_hwdata", HWDATA, 0);
    chk("t6_rst_hresetn", HRESETn, 0);
    chk("t6_rst_hsel", HSEL, 0);
    @(posedge clk); #1 rst = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF);
    idle();
    drain("t6_drain");
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
